// File: rtl/ghr_ckpt.sv
// Speculative global-history register with a checkpoint ring for
// branch-predictor recovery. Each accepted push shifts the predicted
// direction into spec_hist and records the pre-shift history plus the
// predicted bit at the tail. Commits retire from the head into arch_hist;
// a recovery rebuilds spec_hist from the mispredicted branch's checkpoint
// and truncates the ring just after that entry.
module ghr_ckpt #(
  parameter int unsigned HIST_W = 14,
  parameter int unsigned DEPTH  = 8,
  parameter logic [HIST_W-1:0] INIT = '0,
  localparam int unsigned TAG_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spec_valid,
  input  logic              spec_taken,
  output logic              spec_ready,
  output logic [TAG_W-1:0]  spec_tag,
  input  logic              commit_valid,
  input  logic              recover_valid,
  input  logic [TAG_W-1:0]  recover_tag,
  input  logic              recover_taken,
  output logic [HIST_W-1:0] spec_hist,
  output logic [HIST_W-1:0] arch_hist,
  output logic [TAG_W:0]    count,
  output logic              full,
  output logic              empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0] PTR_ONE  = (TAG_W+1)'(1);

  // Pointers carry one extra wrap bit so full and empty stay distinguishable.
  logic [TAG_W:0]    head;
  logic [TAG_W:0]    tail;
  logic [HIST_W-1:0] spec_q;
  logic [HIST_W-1:0] arch_q;

  logic [HIST_W-1:0] ck_hist  [DEPTH];
  logic              ck_taken [DEPTH];

  logic [TAG_W-1:0]  rec_off;
  logic              rec_hit;
  logic              push;
  logic              commit;
  logic              commit_taken;
  logic [TAG_W:0]    rec_tail;

  // Status outputs depend only on registered pointers.
  assign count      = tail - head;
  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign spec_ready = !full;
  assign spec_tag   = tail[TAG_W-1:0];
  assign spec_hist  = spec_q;
  assign arch_hist  = arch_q;

  // Decode which operations take effect this cycle.
  always_comb begin
    rec_off      = recover_tag - head[TAG_W-1:0];
    // Head-relative distance makes the in-flight test immune to tail wrap.
    rec_hit      = recover_valid && ({1'b0, rec_off} < count);
    push         = spec_valid && !full && !rec_hit;
    commit       = commit_valid && !empty;
    commit_taken = ck_taken[head[TAG_W-1:0]];
    if (rec_hit && (recover_tag == head[TAG_W-1:0]))
      commit_taken = recover_taken;
    rec_tail     = head + {1'b0, rec_off} + PTR_ONE;
  end

  // Pointer and history registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head   <= '0;
      tail   <= '0;
      spec_q <= INIT;
      arch_q <= INIT;
    end else begin
      if (rec_hit) begin
        tail   <= rec_tail;
        spec_q <= {ck_hist[recover_tag][HIST_W-2:0], recover_taken};
      end else if (push) begin
        tail   <= tail + PTR_ONE;
        spec_q <= {spec_q[HIST_W-2:0], spec_taken};
      end
      if (commit) begin
        head   <= head + PTR_ONE;
        arch_q <= {arch_q[HIST_W-2:0], commit_taken};
      end
    end
  end

  // Checkpoint storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      ck_hist[tail[TAG_W-1:0]]  <= spec_q;
      ck_taken[tail[TAG_W-1:0]] <= spec_taken;
    end else if (rec_hit) begin
      ck_taken[recover_tag] <= recover_taken;
    end
  end

endmodule

// File: tb/tb_ghr_ckpt.sv
// Directed vector bench for ghr_ckpt (HIST_W=14, DEPTH=8, INIT=0).
module tb_ghr_ckpt;

  localparam int unsigned HIST_W = 14;
  localparam int unsigned DEPTH  = 8;
  localparam int unsigned TAG_W  = 3;

  logic              clk = 1'b0;
  logic              reset;
  logic              spec_valid, spec_taken, spec_ready;
  logic [TAG_W-1:0]  spec_tag;
  logic              commit_valid, recover_valid, recover_taken;
  logic [TAG_W-1:0]  recover_tag;
  logic [HIST_W-1:0] spec_hist, arch_hist;
  logic [TAG_W:0]    count;
  logic              full, empty;

  int tests = 0;
  int fails = 0;

  ghr_ckpt #(.HIST_W(HIST_W), .DEPTH(DEPTH), .INIT('0)) dut (
    .clk(clk), .reset(reset),
    .spec_valid(spec_valid), .spec_taken(spec_taken),
    .spec_ready(spec_ready), .spec_tag(spec_tag),
    .commit_valid(commit_valid),
    .recover_valid(recover_valid), .recover_tag(recover_tag),
    .recover_taken(recover_taken),
    .spec_hist(spec_hist), .arch_hist(arch_hist),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst, sv, st, cv, rv;
    int         rtag;
    logic       rt;
    int         sh, ah, cnt, tag;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rst, logic sv, logic st, logic cv,
                              logic rv, int rtag, logic rt,
                              int sh, int ah, int cnt, int tag);
    vec_t v;
    v.rst = rst; v.sv = sv; v.st = st; v.cv = cv; v.rv = rv;
    v.rtag = rtag; v.rt = rt; v.sh = sh; v.ah = ah; v.cnt = cnt; v.tag = tag;
    return v;
  endfunction

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic drive(input vec_t v);
    reset         = v.rst;
    spec_valid    = v.sv;
    spec_taken    = v.st;
    commit_valid  = v.cv;
    recover_valid = v.rv;
    recover_tag   = TAG_W'(v.rtag);
    recover_taken = v.rt;
  endtask

  task automatic check_state(input int idx, input int sh, input int ah,
                             input int cnt, input int tag);
    check($sformatf("v%0d spec_hist", idx), int'(spec_hist), sh);
    check($sformatf("v%0d arch_hist", idx), int'(arch_hist), ah);
    check($sformatf("v%0d count", idx), int'(count), cnt);
    check($sformatf("v%0d spec_tag", idx), int'(spec_tag), tag);
    check($sformatf("v%0d full", idx), int'(full), int'(cnt == DEPTH));
    check($sformatf("v%0d empty", idx), int'(empty), int'(cnt == 0));
    check($sformatf("v%0d spec_ready", idx), int'(spec_ready), int'(cnt != DEPTH));
  endtask

  initial begin
    int cycles;
    //                rst sv st cv rv tag rt    sh    ah cnt tag
    vq.push_back(mk(1, 1, 1, 1, 1, 0, 1,     0,    0, 0, 0)); // 0 reset, all active
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,     1,    0, 1, 1)); // 1 push T
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,     2,    0, 2, 2)); // 2 push N
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,     5,    0, 3, 3)); // 3 push T
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,    11,    0, 4, 4)); // 4 push T -> 1011
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,    11,    1, 3, 4)); // 5 commit T
    vq.push_back(mk(0, 0, 0, 0, 1, 2, 0,     4,    1, 2, 3)); // 6 recover tag2 N
    vq.push_back(mk(0, 0, 0, 0, 1, 5, 1,     4,    1, 2, 3)); // 7 recover not in flight
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,     4,    2, 1, 3)); // 8 commit N
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,     4,    4, 0, 3)); // 9 commit corrected N
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,     4,    4, 0, 3)); // 10 commit on empty
    vq.push_back(mk(0, 0, 0, 0, 1, 3, 1,     4,    4, 0, 3)); // 11 recover on empty
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,     9,    4, 1, 4)); // 12 push T
    vq.push_back(mk(0, 0, 0, 1, 1, 3, 0,     8,    8, 0, 4)); // 13 recover head + commit
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,    17,    8, 1, 5)); // 14 push T
    vq.push_back(mk(0, 1, 1, 0, 1, 4, 0,    16,    8, 1, 5)); // 15 recover drops push
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,    32,    8, 2, 6)); // 16 push N gets tag 5
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,    65,    8, 3, 7)); // 17
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,   131,    8, 4, 0)); // 18
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,   263,    8, 5, 1)); // 19
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,   527,    8, 6, 2)); // 20
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,  1055,    8, 7, 3)); // 21
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,  2111,    8, 8, 4)); // 22 full
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0,  2111,   16, 7, 4)); // 23 push refused, commit
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,  4222,   16, 8, 5)); // 24 freed slot used
    vq.push_back(mk(0, 0, 0, 1, 1, 1, 0,   526,   32, 4, 2)); // 25 recover past wrap + commit
    vq.push_back(mk(1, 1, 1, 1, 1, 1, 1,     0,    0, 0, 0)); // 26 reset over everything
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,     1,    0, 1, 1)); // 27 T
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,     3,    0, 2, 2)); // 28 T
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,     6,    0, 3, 3)); // 29 N
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,    12,    0, 4, 4)); // 30 N
    vq.push_back(mk(0, 0, 0, 0, 1, 1, 0,     2,    0, 2, 2)); // 31 recover tag1 N
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,     5,    0, 3, 3)); // 32 push gets tag 2
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,     0,    0, 0, 0)); // 33 reset
    for (int i = 1; i <= 8; i++)
      vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,    0, i, i % 8)); // 34..41 fill
    vq.push_back(mk(0, 1, 1, 1, 0, 0, 0,     0,    0, 7, 0)); // 42 full: push dropped
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0,     1,    0, 8, 1)); // 43 wrap to tag 0
    vq.push_back(mk(0, 0, 0, 0, 1, 0, 1,     1,    0, 8, 1)); // 44 recover youngest

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i]);
      @(posedge clk);
      #1;
      check_state(i, vq[i].sh, vq[i].ah, vq[i].cnt, vq[i].tag);
    end

    // Drain the ring: takens at idx 1..7 are N, idx 0 was corrected to T.
    spec_valid    = 1'b0;
    recover_valid = 1'b0;
    commit_valid  = 1'b1;
    cycles = 0;
    while (!empty && cycles < 20) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    commit_valid = 1'b0;
    check("drain cycles", cycles, 8);
    check("drain arch_hist", int'(arch_hist), 1);
    check("drain empty", int'(empty), 1);

    // spec_tag is valid in the push cycle and tracks each allocation.
    spec_valid = 1'b1;
    spec_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pre-push tag %0d", i), int'(spec_tag), (1 + i) % 8);
      @(posedge clk);
      #1;
    end
    spec_valid = 1'b0;
    check("post-push count", int'(count), 3);
    check("post-push spec_hist", int'(spec_hist), 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
